// File: rtl/ecc_scrub_scheduler.sv
// ecc_scrub_scheduler
//  Drives NumBanks ECC scrubbers with one-hot, single-cycle scrub triggers.
//  IDLE:     no triggers.
//  PERIODIC: one trigger every max(interval_i, MinInterval) cycles. Banks are
//            served round-robin over the live bank_mask_i.
//  SWEEP:    BankSize triggers per bank selected at request time, spaced
//            MinInterval apart. Ends with a single-cycle sweep_done_o pulse.
//  The scrubbers' corrected/uncorrectable pulses feed saturating counters, a
//  sticky error flag and the index of the first failing bank.
// Ports
//  clk_i, rst_ni          clock, asynchronous active-low reset
//  enable_i, interval_i   periodic mode enable and trigger spacing
//  bank_mask_i            participating banks
//  sweep_req_i            pulse: start a full sweep
//  clear_i                clear counters and sticky error
//  bit_corrected_i        per-bank corrected-error pulses
//  uncorrectable_i        per-bank uncorrectable-error pulses
//  scrub_trigger_o        per-bank trigger pulses
//  sweep_busy_o           high while the sweep is running
//  sweep_done_o           single-cycle pulse when the sweep ends
//  corr_cnt_o             saturating corrected-error count
//  uncorr_cnt_o           saturating uncorrectable-error count
//  err_o                  sticky uncorrectable-error flag
//  err_bank_o             bank of the first uncorrectable error since clear
module ecc_scrub_scheduler #(
  parameter int NumBanks    = 4,
  parameter int BankSize    = 256,
  parameter int CntWidth    = 16,
  parameter int ErrCntWidth = 8,
  parameter int MinInterval = 4,
  localparam int PtrW = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [CntWidth-1:0]    interval_i,
  input  logic [NumBanks-1:0]    bank_mask_i,
  input  logic                   sweep_req_i,
  input  logic                   clear_i,
  input  logic [NumBanks-1:0]    bit_corrected_i,
  input  logic [NumBanks-1:0]    uncorrectable_i,
  output logic [NumBanks-1:0]    scrub_trigger_o,
  output logic                   sweep_busy_o,
  output logic                   sweep_done_o,
  output logic [ErrCntWidth-1:0] corr_cnt_o,
  output logic [ErrCntWidth-1:0] uncorr_cnt_o,
  output logic                   err_o,
  output logic [PtrW-1:0]        err_bank_o
);

  localparam int RndW = (BankSize > 1) ? $clog2(BankSize) : 1;
  localparam int SumW = ErrCntWidth + $clog2(NumBanks + 1);
  localparam logic [SumW-1:0] CntMax = SumW'({ErrCntWidth{1'b1}});

  typedef enum logic [1:0] {IDLE, PERIODIC, SWEEP} state_e;

  function automatic logic [PtrW-1:0] lowest_set(input logic [NumBanks-1:0] v);
    lowest_set = '0;
    for (int i = NumBanks - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = PtrW'(i);
    end
  endfunction

  function automatic logic [SumW-1:0] popcount(input logic [NumBanks-1:0] v);
    popcount = '0;
    for (int i = 0; i < NumBanks; i++) popcount = popcount + SumW'(v[i]);
  endfunction

  // Sum is computed one carry-chain wider than the counter, so it is clamped, never wrapped.
  function automatic logic [ErrCntWidth-1:0] sat_add(input logic [ErrCntWidth-1:0] base,
                                                     input logic [SumW-1:0] inc);
    logic [SumW-1:0] s;
    s = SumW'(base) + inc;
    sat_add = (s > CntMax) ? ErrCntWidth'(CntMax) : ErrCntWidth'(s);
  endfunction

  state_e                state_reg, state_next;
  logic [CntWidth-1:0]   timer_reg, timer_next;
  logic [PtrW-1:0]       ptr_reg, ptr_next;
  logic [NumBanks-1:0]   snap_reg, snap_next;
  logic [RndW-1:0]       round_reg, round_next;
  logic                  last_reg, last_next;     // final trigger of the sweep already issued
  logic                  done_reg, done_next;     // empty-sweep acknowledge
  logic [ErrCntWidth-1:0] corr_reg, corr_next, uncorr_reg, uncorr_next;
  logic                  err_reg, err_next;
  logic [PtrW-1:0]       err_bank_reg, err_bank_next;

  logic [CntWidth-1:0]   eff_periodic, reload_periodic, reload_sweep;
  logic [NumBanks-1:0]   act_mask, above_ptr, above_fire, trig;
  logic [PtrW-1:0]       skip_idx, fire_idx, adv_idx;
  logic                  wrap, sweep_end, mask_any;

  assign eff_periodic    = (interval_i < CntWidth'(MinInterval)) ? CntWidth'(MinInterval) : interval_i;
  assign reload_periodic = eff_periodic - CntWidth'(1);
  assign reload_sweep    = CntWidth'(MinInterval - 1);
  assign mask_any        = |bank_mask_i;

  // The sweep walks its snapshot; periodic mode follows the live mask.
  assign act_mask = (state_reg == SWEEP) ? snap_reg : bank_mask_i;

  for (genvar gi = 0; gi < NumBanks; gi++) begin : g_above
    assign above_ptr[gi]  = act_mask[gi] && (gi > int'(ptr_reg));
    assign above_fire[gi] = act_mask[gi] && (gi > int'(fire_idx));
  end

  // A disabled bank at ptr is skipped, but the trigger still goes out this cycle.
  assign skip_idx = (|above_ptr) ? lowest_set(above_ptr) : lowest_set(act_mask);
  assign fire_idx = act_mask[ptr_reg] ? ptr_reg : skip_idx;
  assign adv_idx  = (|above_fire) ? lowest_set(above_fire) : lowest_set(act_mask);
  assign wrap     = ~(|above_fire);

  always_comb begin
    state_next = state_reg;
    timer_next = (timer_reg != '0) ? timer_reg - CntWidth'(1) : '0;
    ptr_next   = ptr_reg;
    snap_next  = snap_reg;
    round_next = round_reg;
    last_next  = last_reg;
    done_next  = 1'b0;
    trig       = '0;
    sweep_end  = 1'b0;

    case (state_reg)
      IDLE, PERIODIC: begin
        if (sweep_req_i && mask_any) begin
          state_next = SWEEP;
          snap_next  = bank_mask_i;
          ptr_next   = lowest_set(bank_mask_i);
          round_next = '0;
          last_next  = 1'b0;
          timer_next = '0;
        end else begin
          if (sweep_req_i) done_next = 1'b1;
          if (state_reg == IDLE) begin
            if (enable_i && mask_any) begin
              state_next = PERIODIC;
              timer_next = reload_periodic;
            end
          end else if (!enable_i || !mask_any) begin
            state_next = IDLE;
          end else if (timer_reg == '0) begin
            trig[fire_idx] = 1'b1;
            ptr_next       = adv_idx;
            timer_next     = reload_periodic;
          end
        end
      end
      SWEEP: begin
        if (timer_reg == '0) begin
          if (last_reg) begin
            sweep_end  = 1'b1;
            last_next  = 1'b0;
            state_next = enable_i ? PERIODIC : IDLE;
            timer_next = enable_i ? reload_periodic : '0;
          end else begin
            trig[fire_idx] = 1'b1;
            ptr_next       = adv_idx;
            timer_next     = reload_sweep;
            if (wrap) begin
              if (round_reg == RndW'(BankSize - 1)) last_next = 1'b1;
              else                                  round_next = round_reg + RndW'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Error bookkeeping: new events win over a simultaneous clear.
  always_comb begin
    corr_next     = sat_add(clear_i ? '0 : corr_reg, popcount(bit_corrected_i));
    uncorr_next   = sat_add(clear_i ? '0 : uncorr_reg, popcount(uncorrectable_i));
    err_next      = clear_i ? 1'b0 : err_reg;
    err_bank_next = clear_i ? '0 : err_bank_reg;
    if (|uncorrectable_i) begin
      err_next = 1'b1;
      if (!err_reg || clear_i) err_bank_next = lowest_set(uncorrectable_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      ptr_reg      <= '0;
      snap_reg     <= '0;
      round_reg    <= '0;
      last_reg     <= 1'b0;
      done_reg     <= 1'b0;
      corr_reg     <= '0;
      uncorr_reg   <= '0;
      err_reg      <= 1'b0;
      err_bank_reg <= '0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      ptr_reg      <= ptr_next;
      snap_reg     <= snap_next;
      round_reg    <= round_next;
      last_reg     <= last_next;
      done_reg     <= done_next;
      corr_reg     <= corr_next;
      uncorr_reg   <= uncorr_next;
      err_reg      <= err_next;
      err_bank_reg <= err_bank_next;
    end
  end

  assign scrub_trigger_o = trig;
  assign sweep_busy_o    = (state_reg == SWEEP);
  assign sweep_done_o    = done_reg | sweep_end;
  assign corr_cnt_o      = corr_reg;
  assign uncorr_cnt_o    = uncorr_reg;
  assign err_o           = err_reg;
  assign err_bank_o      = err_bank_reg;

endmodule

// File: tb/tb_ecc_scrub_scheduler.sv
// tb_ecc_scrub_scheduler
//  Directed bench: a table of counter/error vectors plus hand-written
//  sequences for periodic spacing, sweeps, empty sweeps and mid-sweep reset.
module tb_ecc_scrub_scheduler;

  localparam int NB = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          enable_i = 1'b0;
  logic [15:0]   interval_i = '0;
  logic [NB-1:0] bank_mask_i = '0;
  logic          sweep_req_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [NB-1:0] bit_corrected_i = '0;
  logic [NB-1:0] uncorrectable_i = '0;
  logic [NB-1:0] scrub_trigger_o;
  logic          sweep_busy_o, sweep_done_o;
  logic [1:0]    corr_cnt_o, uncorr_cnt_o;
  logic          err_o;
  logic [1:0]    err_bank_o;

  ecc_scrub_scheduler #(
    .NumBanks(NB), .BankSize(8), .CntWidth(16), .ErrCntWidth(2), .MinInterval(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .interval_i(interval_i),
    .bank_mask_i(bank_mask_i), .sweep_req_i(sweep_req_i), .clear_i(clear_i),
    .bit_corrected_i(bit_corrected_i), .uncorrectable_i(uncorrectable_i),
    .scrub_trigger_o(scrub_trigger_o), .sweep_busy_o(sweep_busy_o),
    .sweep_done_o(sweep_done_o), .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o),
    .err_o(err_o), .err_bank_o(err_bank_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  int          ev_cyc[$];
  logic [3:0]  ev_trig[$];
  int          done_cyc[$];
  int          exp_cyc[$];
  logic [3:0]  exp_trig[$];

  typedef struct {
    logic       clr;
    logic [3:0] corr;
    logic [3:0] unc;
    logic [1:0] e_corr;
    logic [1:0] e_unc;
    logic       e_err;
    logic [1:0] e_bank;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    enable_i = 1'b0; interval_i = '0; bank_mask_i = '0; sweep_req_i = 1'b0;
    clear_i = 1'b0; bit_corrected_i = '0; uncorrectable_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  // Cycle 0 is the cycle whose inputs were driven just before the call.
  // Busy is expected high exactly for cycles blo..bhi.
  task automatic collect(input int ncyc, input int blo, input int bhi,
                         input bit toggle_en, input int rereq);
    ev_cyc.delete(); ev_trig.delete(); done_cyc.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk_i);
      if (scrub_trigger_o != '0) begin
        ev_cyc.push_back(c);
        ev_trig.push_back(scrub_trigger_o);
        $display("cycle %0d: trigger=%b busy=%b", c, scrub_trigger_o, sweep_busy_o);
      end
      if (sweep_done_o) begin
        done_cyc.push_back(c);
        $display("cycle %0d: sweep_done", c);
      end
      chk($sformatf("sweep_busy@%0d", c), 32'(sweep_busy_o), 32'(c >= blo && c <= bhi));
      @(posedge clk_i);
      #1;
      sweep_req_i = (c + 1 == rereq);
      if (toggle_en) enable_i = ~enable_i;
    end
  endtask

  task automatic check_events(input string name);
    chk({name, " trigger count"}, ev_cyc.size(), exp_cyc.size());
    for (int i = 0; i < ev_cyc.size() && i < exp_cyc.size(); i++) begin
      chk($sformatf("%s trig%0d cycle", name, i), ev_cyc[i], exp_cyc[i]);
      chk($sformatf("%s trig%0d bank", name, i), 32'(ev_trig[i]), 32'(exp_trig[i]));
    end
  endtask

  initial begin
    //              clr  corr     unc      corr unc err bank
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0, 2'd0};
    vecs[1]  = '{1'b0, 4'b1011, 4'b0000, 2'd3, 2'd0, 1'b0, 2'd0};
    vecs[2]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0, 2'd0};
    vecs[3]  = '{1'b0, 4'b0001, 4'b0000, 2'd1, 2'd0, 1'b0, 2'd0};
    vecs[4]  = '{1'b0, 4'b0011, 4'b0000, 2'd3, 2'd0, 1'b0, 2'd0};
    vecs[5]  = '{1'b0, 4'b0001, 4'b0000, 2'd3, 2'd0, 1'b0, 2'd0};
    vecs[6]  = '{1'b0, 4'b1111, 4'b0000, 2'd3, 2'd0, 1'b0, 2'd0};
    vecs[7]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0, 2'd0};
    vecs[8]  = '{1'b0, 4'b0000, 4'b0100, 2'd0, 2'd1, 1'b1, 2'd2};
    vecs[9]  = '{1'b0, 4'b0000, 4'b0001, 2'd0, 2'd2, 1'b1, 2'd2};
    vecs[10] = '{1'b1, 4'b0000, 4'b1000, 2'd0, 2'd1, 1'b1, 2'd3};
    vecs[11] = '{1'b0, 4'b0000, 4'b1010, 2'd0, 2'd3, 1'b1, 2'd3};
    vecs[12] = '{1'b0, 4'b0000, 4'b0001, 2'd0, 2'd3, 1'b1, 2'd3};
    vecs[13] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 2'd0, 1'b0, 2'd0};
    vecs[14] = '{1'b1, 4'b0110, 4'b0000, 2'd2, 2'd0, 1'b0, 2'd0};
    vecs[15] = '{1'b0, 4'b0001, 4'b0010, 2'd3, 2'd1, 1'b1, 2'd1};

    // Reset values
    do_reset();
    @(negedge clk_i);
    chk("reset trigger", 32'(scrub_trigger_o), 0);
    chk("reset busy", 32'(sweep_busy_o), 0);
    chk("reset done", 32'(sweep_done_o), 0);
    chk("reset corr", 32'(corr_cnt_o), 0);
    chk("reset uncorr", 32'(uncorr_cnt_o), 0);
    chk("reset err", 32'(err_o), 0);
    chk("reset err_bank", 32'(err_bank_o), 0);

    // Periodic, interval 10, all banks
    @(posedge clk_i); #1;
    enable_i = 1'b1; interval_i = 16'd10; bank_mask_i = 4'b1111;
    collect(55, 1, 0, 1'b0, -1);
    exp_cyc = '{10, 20, 30, 40, 50};
    exp_trig = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    check_events("periodic10");
    // Disabling leaves PERIODIC at once: the trigger due at cycle 5 never appears
    enable_i = 1'b0;
    collect(15, 1, 0, 1'b0, -1);
    exp_cyc.delete(); exp_trig.delete();
    check_events("periodic exit");

    // Interval below the minimum clamps to 4; banks 1 and 3 are skipped
    do_reset();
    @(posedge clk_i); #1;
    enable_i = 1'b1; interval_i = 16'd1; bank_mask_i = 4'b0101;
    collect(18, 1, 0, 1'b0, -1);
    exp_cyc = '{4, 8, 12, 16};
    exp_trig = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    check_events("clamp");

    // Sweep over banks 0,1 (8 lines each), enable toggling and a repeated request ignored
    do_reset();
    @(posedge clk_i); #1;
    interval_i = 16'd10; bank_mask_i = 4'b0011; sweep_req_i = 1'b1;
    collect(72, 1, 65, 1'b1, 30);
    exp_cyc.delete(); exp_trig.delete();
    for (int k = 0; k < 16; k++) begin
      exp_cyc.push_back(1 + 4 * k);
      exp_trig.push_back((k % 2 == 0) ? 4'b0001 : 4'b0010);
    end
    check_events("sweep");
    chk("sweep done count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("sweep done cycle", done_cyc[0], 65);

    // Sweep with empty mask: only a done pulse on the next cycle
    do_reset();
    @(posedge clk_i); #1;
    bank_mask_i = 4'b0000; sweep_req_i = 1'b1;
    collect(6, 1, 0, 1'b0, -1);
    exp_cyc.delete(); exp_trig.delete();
    check_events("empty sweep");
    chk("empty done count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("empty done cycle", done_cyc[0], 1);

    // Reset in the middle of a sweep abandons it without a done pulse
    do_reset();
    @(posedge clk_i); #1;
    bank_mask_i = 4'b1111; sweep_req_i = 1'b1;
    collect(10, 1, 20, 1'b0, -1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midreset busy", 32'(sweep_busy_o), 0);
    chk("midreset trigger", 32'(scrub_trigger_o), 0);
    chk("midreset done", 32'(sweep_done_o), 0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    collect(20, 1, 0, 1'b0, -1);
    exp_cyc.delete(); exp_trig.delete();
    check_events("after midreset");
    chk("after midreset done count", done_cyc.size(), 0);

    // Counter and sticky-error vectors, one per cycle
    do_reset();
    for (int i = 0; i < 16; i++) begin
      clear_i = vecs[i].clr;
      bit_corrected_i = vecs[i].corr;
      uncorrectable_i = vecs[i].unc;
      @(posedge clk_i); #1;
      $display("vec %0d: clr=%b corr=%b unc=%b -> corr_cnt=%0d uncorr_cnt=%0d err=%b bank=%0d",
               i, vecs[i].clr, vecs[i].corr, vecs[i].unc, corr_cnt_o, uncorr_cnt_o, err_o, err_bank_o);
      chk($sformatf("vec%0d corr_cnt", i), 32'(corr_cnt_o), 32'(vecs[i].e_corr));
      chk($sformatf("vec%0d uncorr_cnt", i), 32'(uncorr_cnt_o), 32'(vecs[i].e_unc));
      chk($sformatf("vec%0d err", i), 32'(err_o), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d err_bank", i), 32'(err_bank_o), 32'(vecs[i].e_bank));
    end
    clear_i = 1'b0; bit_corrected_i = '0; uncorrectable_i = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
